// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial two's-complement adder/subtractor
// One full-adder slice with a registered carry; operands are consumed LSB-first, one bit per clock.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s;
  logic             c_next;
  logic             last;
  logic [WIDTH-1:0] acc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sh_d     = sh_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    s      = opa_q[0] ^ opb_q[0] ^ carry_q;
    c_next = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    last   = (cnt_q == CW'(WIDTH - 1));
    acc    = {s, sh_q};

    case (state_q)
      S_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sh_d    = acc[WIDTH-1:1];
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // On the final step opa_q[0]/opb_q[0] are the operand MSBs.
          state_d  = S_DONE;
          result_d = acc;
          cout_d   = c_next;
          ovf_d    = (opa_q[0] == opb_q[0]) && (s != opa_q[0]);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          state_d = S_RUN;
          opa_d   = a;
          opb_d   = op ? ~b : b;
          carry_d = op;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sh_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sh_q     <= sh_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
